scariv_ldq_array: RTL and testbench
===================================

SCARIV_LDQ_ARRAY -- requirements
Module: scariv_ldq_array

Interface
REQ-001 SHALL have parameter LDQ_SIZE, default 16: entry count, power of two, at least 4; IDX_W = log2(LDQ_SIZE).
REQ-002 SHALL have parameter DISP_WIDTH, default 2: allocation ports and maximum retirements per cycle.
REQ-003 SHALL have parameter EX_PORTS, default 2: EX2 address-update ports.
REQ-004 SHALL have parameter CMT_W, default 6: cmt_id width; the MSB is the wrap bit.
REQ-005 SHALL have parameter PADDR_W, default 40: physical address width.
REQ-006 SHALL use i_clk as clock and i_reset_n as reset (asynchronous, active-low).
REQ-007 i_clk  in  1  clock.
REQ-008 i_reset_n  in  1  async active-low reset.
REQ-009 i_disp_valid  in  DISP_WIDTH  per-port load allocate request; set bits are contiguous from bit 0.
REQ-010 i_disp_cmt_id  in  DISP_WIDTH*CMT_W  cmt_id per allocate port.
REQ-011 o_disp_ready  out  1  free entries >= DISP_WIDTH.
REQ-012 o_disp_index  out  DISP_WIDTH*IDX_W  entry index assigned to port k = tail+k mod LDQ_SIZE.
REQ-013 i_ex2_valid  in  EX_PORTS  address update valid.
REQ-014 i_ex2_index  in  EX_PORTS*IDX_W  target entry.
REQ-015 i_ex2_paddr  in  EX_PORTS*PADDR_W  physical address.
REQ-016 i_ex2_size  in  EX_PORTS*3  access size code.
REQ-017 i_cmt_valid  in  1  commit of the group i_cmt_id.
REQ-018 i_cmt_id  in  CMT_W  committed group id.
REQ-019 i_cmt_flush  in  1  qualifies i_cmt_valid: flushed commit, kills all valid entries.
REQ-020 i_br_valid  in  1  branch mispredict flush.
REQ-021 i_br_cmt_id  in  CMT_W  cmt_id of the mispredicted branch.
REQ-022 o_retire_valid  out  DISP_WIDTH  entries freed this cycle, contiguous from bit 0.
REQ-023 o_count  out  IDX_W+1  valid entry count.
REQ-024 o_full / o_empty  out  1 each  count == LDQ_SIZE / count == 0.

Function
REQ-025 Each entry SHALL hold valid, dead, committed, paddr_valid, cmt_id, paddr and size; head and tail pointers SHALL be IDX_W+1 bits with a wrap bit.
REQ-026 Allocation SHALL occur only when o_disp_ready is high; requests made while it is low SHALL be ignored with no state change (caller-side handshake).
REQ-027 An allocated entry SHALL become valid next cycle with paddr_valid=0 and committed=0; tail SHALL advance by popcount(i_disp_valid).
REQ-028 An entry allocated while i_cmt_flush&i_cmt_valid is high, or while i_br_valid is high with its cmt_id younger than i_br_cmt_id, SHALL be allocated with dead=1.
REQ-029 Younger test: the cmt_id values differ in MSB XOR (entry low bits > branch low bits); equal ids SHALL NOT be flushed.
REQ-030 i_cmt_flush&i_cmt_valid SHALL set dead on every valid entry next cycle; i_br_valid SHALL set dead on every valid entry younger than i_br_cmt_id.
REQ-031 An EX2 update SHALL write paddr/size and set paddr_valid only if the target is valid, not dead, not committed and paddr_valid=0, and no flush hits it in the same cycle.
REQ-032 Multiple EX2 ports targeting the same entry in one cycle: the lowest-index port SHALL win.
REQ-033 i_cmt_valid without flush SHALL set committed on every valid, non-dead entry whose cmt_id equals i_cmt_id.
REQ-034 Retirement SHALL free up to DISP_WIDTH consecutive entries from head whose committed or dead flag is registered high, stopping at the first entry not in that state; head SHALL advance accordingly and o_retire_valid SHALL be registered in the same cycle as the free.
REQ-035 Freed entries SHALL be reusable in the cycle after retirement; o_count SHALL equal the previous count + allocated - retired, with simultaneous allocate and retire both applied.
REQ-036 Pointers SHALL wrap modulo LDQ_SIZE; full vs. empty SHALL be distinguished by the wrap bit.

Reset
REQ-037 Async reset SHALL clear all valid flags and zero head and tail, giving o_count=0, o_empty=1, o_full=0, o_disp_ready=1, o_retire_valid=0 and o_disp_index={DISP_WIDTH-1..0}; reset mid-operation SHALL discard all entries.

Verification
REQ-038 Reset, then allocate 2 per cycle for 8 cycles -> o_full=1, o_disp_ready=0, o_count=16; a 9th request -> no change.
REQ-039 Entry 3 updated by port 0 and port 1 in the same cycle (paddr 0x1000 / 0x2000) -> entry 3 paddr=0x1000; a later update is ignored.
REQ-040 Entries with cmt_id 4,5,6 at head; commit 4 then 5 -> o_retire_valid=01, then 01; entry 6 remains, o_count=1.
REQ-041 Entries with cmt_id 0x3E,0x3F,0x00,0x01; i_br_valid with i_br_cmt_id=0x3F -> entries 0x00 and 0x01 dead, 0x3F not; after committing 0x3E and 0x3F, all 4 retire within 2 cycles.
REQ-042 Flushed commit in the same cycle as a 2-wide allocate -> all entries, including the new ones, dead; the queue drains to o_empty=1 with tail and head wrapped consistently.

Source files
------------

// File: rtl/scariv_ldq_array.sv
// Load queue entry array: in-order allocation at tail, out-of-order address fill
// from EX2, commit/branch flush marking, and up to DISP_WIDTH in-order retirements at head.
module scariv_ldq_array #(
  parameter int LDQ_SIZE   = 16,
  parameter int DISP_WIDTH = 2,
  parameter int EX_PORTS   = 2,
  parameter int CMT_W      = 6,
  parameter int PADDR_W    = 40,
  localparam int IDX_W     = $clog2(LDQ_SIZE)
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [DISP_WIDTH-1:0]         i_disp_valid,
  input  logic [DISP_WIDTH*CMT_W-1:0]   i_disp_cmt_id,
  output logic                          o_disp_ready,
  output logic [DISP_WIDTH*IDX_W-1:0]   o_disp_index,
  input  logic [EX_PORTS-1:0]           i_ex2_valid,
  input  logic [EX_PORTS*IDX_W-1:0]     i_ex2_index,
  input  logic [EX_PORTS*PADDR_W-1:0]   i_ex2_paddr,
  input  logic [EX_PORTS*3-1:0]         i_ex2_size,
  input  logic                          i_cmt_valid,
  input  logic [CMT_W-1:0]              i_cmt_id,
  input  logic                          i_cmt_flush,
  input  logic                          i_br_valid,
  input  logic [CMT_W-1:0]              i_br_cmt_id,
  output logic [DISP_WIDTH-1:0]         o_retire_valid,
  output logic [IDX_W:0]                o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(LDQ_SIZE);
  localparam logic [IDX_W:0] READY_MAX  = (IDX_W+1)'(LDQ_SIZE - DISP_WIDTH);

  logic [IDX_W:0]         head_reg;
  logic [IDX_W:0]         tail_reg;
  logic [IDX_W:0]         count;
  logic [IDX_W:0]         disp_cnt;
  logic [IDX_W:0]         retire_cnt;
  logic                   alloc_en;
  logic                   cmt_flush;
  logic [DISP_WIDTH-1:0]  retire_ok;
  logic [DISP_WIDTH-1:0]  retire;
  logic [DISP_WIDTH-1:0]  retire_valid_reg;

  logic [LDQ_SIZE-1:0]    valid_reg;
  logic [LDQ_SIZE-1:0]    dead_reg;
  logic [LDQ_SIZE-1:0]    committed_reg;
  logic [LDQ_SIZE-1:0]    paddr_valid_reg;
  logic [CMT_W-1:0]       cmt_id_reg [LDQ_SIZE];
  logic [PADDR_W-1:0]     paddr_reg  [LDQ_SIZE];
  logic [2:0]             size_reg   [LDQ_SIZE];

  // Wrap-bit age compare; identical ids are never considered younger.
  function automatic logic is_younger(input logic [CMT_W-1:0] a, input logic [CMT_W-1:0] b);
    return (a[CMT_W-1] ^ b[CMT_W-1]) ^ (a[CMT_W-2:0] > b[CMT_W-2:0]);
  endfunction

  assign count          = tail_reg - head_reg;
  assign o_count        = count;
  assign o_full         = (count == FULL_COUNT);
  assign o_empty        = (count == '0);
  assign o_disp_ready   = (count <= READY_MAX);
  assign o_retire_valid = retire_valid_reg;
  assign alloc_en       = o_disp_ready;
  assign cmt_flush      = i_cmt_valid & i_cmt_flush;

  always_comb begin
    disp_cnt   = '0;
    retire_cnt = '0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      disp_cnt   = disp_cnt + {{IDX_W{1'b0}}, i_disp_valid[k]};
      retire_cnt = retire_cnt + {{IDX_W{1'b0}}, retire[k]};
    end
  end

  for (genvar gi = 0; gi < DISP_WIDTH; gi++) begin : g_port
    logic [IDX_W-1:0] head_idx;
    assign head_idx = head_reg[IDX_W-1:0] + IDX_W'(gi);
    assign retire_ok[gi] = valid_reg[head_idx] & (dead_reg[head_idx] | committed_reg[head_idx]);
    assign o_disp_index[gi*IDX_W +: IDX_W] = tail_reg[IDX_W-1:0] + IDX_W'(gi);
  end

  // Retirement stops at the first head entry that is neither committed nor dead.
  always_comb begin
    logic run;
    run    = 1'b1;
    retire = '0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      run       = run & retire_ok[k];
      retire[k] = run;
    end
  end

  for (genvar gi = 0; gi < LDQ_SIZE; gi++) begin : g_entry
    logic               alloc_hit;
    logic [CMT_W-1:0]   alloc_id;
    logic               alloc_dead;
    logic               retire_hit;
    logic               ex2_hit;
    logic [PADDR_W-1:0] ex2_paddr;
    logic [2:0]         ex2_size;
    logic               flush_hit;
    logic               commit_hit;
    logic               ex2_ok;

    always_comb begin
      alloc_hit  = 1'b0;
      alloc_id   = '0;
      retire_hit = 1'b0;
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (alloc_en && i_disp_valid[k] &&
            ((tail_reg[IDX_W-1:0] + IDX_W'(k)) == IDX_W'(gi))) begin
          alloc_hit = 1'b1;
          alloc_id  = i_disp_cmt_id[k*CMT_W +: CMT_W];
        end
        if (retire[k] && ((head_reg[IDX_W-1:0] + IDX_W'(k)) == IDX_W'(gi)))
          retire_hit = 1'b1;
      end
    end

    // Scan downwards so the lowest-numbered matching port overrides the others.
    always_comb begin
      ex2_hit   = 1'b0;
      ex2_paddr = '0;
      ex2_size  = '0;
      for (int k = EX_PORTS - 1; k >= 0; k--) begin
        if (i_ex2_valid[k] && (i_ex2_index[k*IDX_W +: IDX_W] == IDX_W'(gi))) begin
          ex2_hit   = 1'b1;
          ex2_paddr = i_ex2_paddr[k*PADDR_W +: PADDR_W];
          ex2_size  = i_ex2_size[k*3 +: 3];
        end
      end
    end

    assign alloc_dead = cmt_flush | (i_br_valid & is_younger(alloc_id, i_br_cmt_id));
    assign flush_hit  = cmt_flush | (i_br_valid & is_younger(cmt_id_reg[gi], i_br_cmt_id));
    assign commit_hit = i_cmt_valid & ~i_cmt_flush & ~dead_reg[gi] & (cmt_id_reg[gi] == i_cmt_id);
    assign ex2_ok     = ex2_hit & valid_reg[gi] & ~dead_reg[gi] & ~committed_reg[gi] &
                        ~paddr_valid_reg[gi] & ~flush_hit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        valid_reg[gi]       <= 1'b0;
        dead_reg[gi]        <= 1'b0;
        committed_reg[gi]   <= 1'b0;
        paddr_valid_reg[gi] <= 1'b0;
      end else if (alloc_hit) begin
        valid_reg[gi]       <= 1'b1;
        dead_reg[gi]        <= alloc_dead;
        committed_reg[gi]   <= 1'b0;
        paddr_valid_reg[gi] <= 1'b0;
      end else if (retire_hit) begin
        valid_reg[gi]       <= 1'b0;
      end else if (valid_reg[gi]) begin
        dead_reg[gi]        <= dead_reg[gi] | flush_hit;
        committed_reg[gi]   <= committed_reg[gi] | commit_hit;
        paddr_valid_reg[gi] <= paddr_valid_reg[gi] | ex2_ok;
      end
    end

    always_ff @(posedge i_clk) begin
      if (alloc_hit)
        cmt_id_reg[gi] <= alloc_id;
      if (ex2_ok) begin
        paddr_reg[gi] <= ex2_paddr;
        size_reg[gi]  <= ex2_size;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      retire_valid_reg <= '0;
    end else begin
      head_reg         <= head_reg + retire_cnt;
      tail_reg         <= tail_reg + (alloc_en ? disp_cnt : '0);
      retire_valid_reg <= retire;
    end
  end

endmodule

// File: tb/tb_scariv_ldq_array.sv
// Scoreboarded bench for scariv_ldq_array: a queue-based load-queue model predicts
// each cycle's registered outputs; a monitor compares them one cycle later.
module tb_scariv_ldq_array;

  localparam int LDQ_SIZE = 16;
  localparam int DW       = 2;
  localparam int IDX_W    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  disp_valid;
  logic [11:0] disp_cmt_id;
  logic        disp_ready;
  logic [7:0]  disp_index;
  logic [1:0]  ex2_valid;
  logic [7:0]  ex2_index;
  logic [79:0] ex2_paddr;
  logic [5:0]  ex2_size;
  logic        cmt_valid;
  logic [5:0]  cmt_id;
  logic        cmt_flush;
  logic        br_valid;
  logic [5:0]  br_cmt_id;
  logic [1:0]  retire_valid;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  always #5 clk = ~clk;

  scariv_ldq_array dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_disp_valid(disp_valid), .i_disp_cmt_id(disp_cmt_id),
    .o_disp_ready(disp_ready), .o_disp_index(disp_index),
    .i_ex2_valid(ex2_valid), .i_ex2_index(ex2_index),
    .i_ex2_paddr(ex2_paddr), .i_ex2_size(ex2_size),
    .i_cmt_valid(cmt_valid), .i_cmt_id(cmt_id), .i_cmt_flush(cmt_flush),
    .i_br_valid(br_valid), .i_br_cmt_id(br_cmt_id),
    .o_retire_valid(retire_valid), .o_count(count),
    .o_full(full), .o_empty(empty)
  );

  typedef struct {
    logic [5:0]  id;
    bit          dead;
    bit          comm;
    bit          pv;
    logic [39:0] paddr;
  } ent_t;

  typedef struct {
    logic [1:0] ret;
    int         cnt;
    bit         rdy;
    bit         full;
    bit         empty;
    logic [7:0] didx;
  } exp_t;

  ent_t mq[$];     // live entries, oldest first
  int   m_head;    // head pointer including wrap bit (0..2*LDQ_SIZE-1)
  exp_t eq[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  logic [5:0] nid = 6'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit younger(input logic [5:0] a, input logic [5:0] b);
    return (a[5] ^ b[5]) ^ (a[4:0] > b[4:0]);
  endfunction

  // One clock of architectural behaviour, then queue the expected post-edge outputs.
  task automatic model_step();
    ent_t old[$];
    ent_t n;
    bit   taken[LDQ_SIZE];
    bit   fh;
    bit   rdy;
    int   r;
    int   pos;
    int   tail;
    exp_t e;
    old = mq;
    for (int i = 0; i < LDQ_SIZE; i++) taken[i] = 1'b0;
    r = 0;
    while (r < DW && r < mq.size() && (mq[r].dead || mq[r].comm)) r++;
    rdy = (LDQ_SIZE - mq.size()) >= DW;
    foreach (mq[i]) begin
      fh = (cmt_valid && cmt_flush) || (br_valid && younger(old[i].id, br_cmt_id));
      if (cmt_valid && !cmt_flush && !old[i].dead && old[i].id == cmt_id) mq[i].comm = 1'b1;
      if (fh) mq[i].dead = 1'b1;
    end
    for (int p = 0; p < 2; p++) begin
      if (ex2_valid[p]) begin
        pos = (int'(ex2_index[p*4 +: 4]) - (m_head % LDQ_SIZE) + LDQ_SIZE) % LDQ_SIZE;
        if (pos < old.size() && !taken[pos]) begin
          taken[pos] = 1'b1;
          fh = (cmt_valid && cmt_flush) || (br_valid && younger(old[pos].id, br_cmt_id));
          if (!old[pos].dead && !old[pos].comm && !old[pos].pv && !fh) begin
            mq[pos].pv    = 1'b1;
            mq[pos].paddr = ex2_paddr[p*40 +: 40];
          end
        end
      end
    end
    repeat (r) void'(mq.pop_front());
    m_head = (m_head + r) % (2 * LDQ_SIZE);
    if (rdy) begin
      for (int k = 0; k < DW; k++) begin
        if (disp_valid[k]) begin
          n.id    = disp_cmt_id[k*6 +: 6];
          n.dead  = (cmt_valid && cmt_flush) || (br_valid && younger(n.id, br_cmt_id));
          n.comm  = 1'b0;
          n.pv    = 1'b0;
          n.paddr = '0;
          mq.push_back(n);
        end
      end
    end
    tail    = (m_head + mq.size()) % LDQ_SIZE;
    e.ret   = 2'((1 << r) - 1);
    e.cnt   = mq.size();
    e.rdy   = (LDQ_SIZE - mq.size()) >= DW;
    e.full  = (mq.size() == LDQ_SIZE);
    e.empty = (mq.size() == 0);
    e.didx  = {4'(tail + 1), 4'(tail)};
    eq.push_back(e);
  endtask

  task automatic clear_in();
    disp_valid = '0; disp_cmt_id = '0;
    ex2_valid = '0; ex2_index = '0; ex2_paddr = '0; ex2_size = '0;
    cmt_valid = 1'b0; cmt_id = '0; cmt_flush = 1'b0;
    br_valid = 1'b0; br_cmt_id = '0;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    clear_in();
  endtask

  task automatic alloc(input logic [1:0] v, input logic [5:0] a, input logic [5:0] b);
    disp_valid  = v;
    disp_cmt_id = {b, a};
  endtask

  task automatic commit(input logic [5:0] id);
    cmt_valid = 1'b1;
    cmt_id    = id;
  endtask

  initial begin : monitor
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("retire_valid", retire_valid, e.ret);
        chk("count", count, e.cnt);
        chk("disp_ready", disp_ready, e.rdy);
        chk("full", full, e.full);
        chk("empty", empty, e.empty);
        chk("disp_index", disp_index, e.didx);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int t;
    clear_in();
    m_head = 0;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_retire", retire_valid, 0);
    chk("rst_disp_index", disp_index, 8'h10);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Fill to capacity, then a rejected ninth request
    for (int c = 0; c < 8; c++) begin
      alloc(2'b11, 6'(2*c), 6'(2*c + 1));
      tick();
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_ready", disp_ready, 0);
    alloc(2'b11, 6'h30, 6'h31);
    tick();
    chk("over_count", count, 16);
    chk("over_full", full, 1);
    for (int c = 0; c < 16; c++) begin
      commit(6'(c));
      tick();
    end
    repeat (3) tick();
    chk("drain_empty", empty, 1);

    // Commit 4 then 5; entry 6 stays
    alloc(2'b11, 6'd4, 6'd5); tick();
    alloc(2'b01, 6'd6, 6'd0); tick();
    commit(6'd4); tick();
    commit(6'd5); tick();
    chk("cmt4_retire", retire_valid, 2'b01);
    tick();
    chk("cmt5_retire", retire_valid, 2'b01);
    tick();
    chk("cmt_left_count", count, 1);
    commit(6'd6); tick();
    repeat (2) tick();

    // Two EX2 ports hit entry 3 together; port 0 wins and later writes are ignored
    chk("ex2_tail_idx", disp_index[3:0], 4'd3);
    alloc(2'b11, 6'd7, 6'd8); tick();
    ex2_valid = 2'b11; ex2_index = {4'd3, 4'd3};
    ex2_paddr = {40'h2000, 40'h1000}; tick();
    ex2_valid = 2'b01; ex2_index = {4'd0, 4'd3};
    ex2_paddr = {40'h0, 40'h3000}; tick();
    tick();
    chk("ex2_paddr_e3", dut.paddr_reg[3], 40'h1000);
    chk("ex2_pvalid_e3", dut.paddr_valid_reg[3], 1);
    commit(6'd7); tick();
    commit(6'd8); tick();
    repeat (3) tick();

    // Branch flush across the cmt_id wrap
    alloc(2'b11, 6'h3E, 6'h3F); tick();
    alloc(2'b11, 6'h00, 6'h01); tick();
    br_valid = 1'b1; br_cmt_id = 6'h3F; tick();
    commit(6'h3E); tick();
    commit(6'h3F); tick();
    repeat (3) tick();
    chk("br_empty", empty, 1);

    // Flushed commit together with a 2-wide allocate
    alloc(2'b11, 6'h0A, 6'h0B); tick();
    alloc(2'b11, 6'h0C, 6'h0D); tick();
    alloc(2'b11, 6'h0E, 6'h0F); commit(6'h0A); cmt_flush = 1'b1; tick();
    chk("flush_count", count, 6);
    repeat (4) tick();
    chk("flush_empty", empty, 1);
    chk("flush_count0", count, 0);

    // Randomised traffic
    nid = 6'h10;
    for (int c = 0; c < 400; c++) begin
      n = $urandom_range(0, 2);
      disp_valid  = 2'((1 << n) - 1);
      disp_cmt_id = {nid + 6'd1, nid};
      if ((LDQ_SIZE - mq.size()) >= DW) nid = nid + 6'(n);
      ex2_valid = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        if (mq.size() > 0 && $urandom_range(0, 1) == 1)
          ex2_index[p*4 +: 4] = 4'((m_head + $urandom_range(0, mq.size() - 1)) % LDQ_SIZE);
        else
          ex2_index[p*4 +: 4] = 4'($urandom_range(0, 15));
      end
      ex2_paddr = {8'($urandom), 32'($urandom), 8'($urandom), 32'($urandom)};
      ex2_size  = 6'($urandom_range(0, 63));
      if (mq.size() > 0 && $urandom_range(0, 9) < 4) begin
        cmt_valid = 1'b1;
        cmt_id    = ($urandom_range(0, 3) == 0) ? mq[$urandom_range(0, mq.size() - 1)].id : mq[0].id;
        cmt_flush = ($urandom_range(0, 39) == 0);
      end
      if (mq.size() > 0 && $urandom_range(0, 24) == 0) begin
        br_valid  = 1'b1;
        br_cmt_id = mq[$urandom_range(0, mq.size() - 1)].id;
      end
      tick();
    end
    repeat (10) tick();

    // Reset in the middle of operation discards everything
    alloc(2'b11, 6'h20, 6'h21); tick();
    t = 0;
    while (eq.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_ready", disp_ready, 1);
    chk("midrst_retire", retire_valid, 0);
    mq.delete();
    m_head = 0;
    @(negedge clk);
    rst_n = 1'b1;
    alloc(2'b01, 6'h22, 6'h00); tick();
    chk("postrst_count", count, 1);
    commit(6'h22); tick();
    repeat (3) tick();

    t = 0;
    while (eq.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (eq.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, required 0", eq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
